// File: rtl/uart_mem_dump.sv
// uart_mem_dump: reads a block of bytes from a synchronous-read memory port
// and sends them on an 8N1 UART TX line (LSB first), followed by an XOR
// checksum frame. Bit timing comes from an external 16x oversampling tick.
module uart_mem_dump #(
  parameter int ADDR_W = 8,
  parameter int OVS    = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Tick,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] Len,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [7:0]        MemRdData,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  localparam int CNT_W = (OVS > 1) ? $clog2(OVS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP,
    S_CSUM
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic [2:0]        r_bit_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic [7:0]        r_shift;
  logic [7:0]        r_csum;
  logic              r_csum_sent;
  logic              r_tx;
  logic              r_done;
  logic              w_accept;
  logic              w_bit_end;
  logic              w_in_bit;

  // A request is only taken in IDLE, with a non-empty block, and not during
  // the Done cycle (Busy is still high there).
  assign w_accept  = (r_state == S_IDLE) && Start && (Len != '0) && !r_done;
  assign w_in_bit  = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_bit_end = w_in_bit && Tick && (r_tick_cnt == CNT_W'(OVS - 1));

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_FETCH;
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
          if (r_rem != '0)      w_next = S_FETCH;
          else if (!r_csum_sent) w_next = S_CSUM;
          else                   w_next = S_IDLE;
        end
      end
      S_CSUM:  w_next = S_START;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Control counters, TX line register and Done pulse
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_csum_sent <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= (r_state == S_STOP) && w_bit_end && r_csum_sent;

      // Tx follows the state one cycle late; every bit is delayed equally,
      // so bit lengths are preserved and the line comes straight from a flop.
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[r_bit_idx];
        default: r_tx <= 1'b1;
      endcase

      // Tick counter restarts on every bit boundary, so a Tick on the
      // boundary cycle belongs to the bit that is ending.
      if ((w_next != r_state) || ((r_state == S_DATA) && w_bit_end))
        r_tick_cnt <= '0;
      else if (w_in_bit && Tick)
        r_tick_cnt <= r_tick_cnt + 1'b1;

      if (r_state == S_START)
        r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_bit_end)
        r_bit_idx <= r_bit_idx + 1'b1;

      if (w_accept) begin
        r_addr      <= StartAddr;
        r_rem       <= Len;
        r_csum_sent <= 1'b0;
      end else if (r_state == S_LATCH) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end else if (r_state == S_CSUM) begin
        r_csum_sent <= 1'b1;
      end
    end
  end

  // Shift register and running checksum (data path, no reset needed:
  // both are loaded before use on every dump)
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_csum <= 8'h00;
    end else if (r_state == S_LATCH) begin
      r_shift <= MemRdData;
      r_csum  <= r_csum ^ MemRdData;
    end else if (r_state == S_CSUM) begin
      r_shift <= r_csum;
    end
  end

  assign MemAddr = r_addr;
  assign MemRdEn = (r_state == S_FETCH);
  assign Tx      = r_tx;
  assign Done    = r_done;
  assign Busy    = (r_state != S_IDLE) || r_done;

endmodule

// File: tb/tb_uart_mem_dump.sv
// Directed testbench for uart_mem_dump: memory model, tick generator and a
// tick-counting UART frame receiver; each scenario task checks inline.
module tb_uart_mem_dump;

  logic       Clk;
  logic       Rst;
  logic       Tick;
  logic       Start;
  logic [7:0] StartAddr;
  logic [7:0] Len;
  logic [7:0] MemAddr;
  logic       MemRdEn;
  logic [7:0] MemRdData;
  logic       Tx;
  logic       Busy;
  logic       Done;

  logic [7:0] mem [256];
  logic [7:0] addr_q [$];
  int         errors = 0;
  int         checks = 0;
  bit         tick_rand = 1'b0;
  int         tick_per = 1;

  uart_mem_dump #(.ADDR_W(8), .OVS(16)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Tick      (Tick),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Len       (Len),
    .MemAddr   (MemAddr),
    .MemRdEn   (MemRdEn),
    .MemRdData (MemRdData),
    .Tx        (Tx),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Tick generator: fixed period or random 1..20 Clks between ticks
  initial begin
    int cnt;
    Tick = 1'b0;
    cnt  = 1;
    forever begin
      @(negedge Clk);
      if (cnt <= 1) begin
        Tick = 1'b1;
        cnt  = tick_rand ? int'($urandom_range(1, 20)) : tick_per;
      end else begin
        Tick = 1'b0;
        cnt  = cnt - 1;
      end
    end
  end

  // Synchronous-read memory model; logs every fetched address
  initial begin
    logic       en;
    logic [7:0] a;
    MemRdData = 8'h00;
    forever begin
      @(negedge Clk);
      en = MemRdEn;
      a  = MemAddr;
      @(posedge Clk);
      #1;
      if (en) begin
        MemRdData = mem[a];
        addr_q.push_back(a);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic start_dump(input logic [7:0] a, input logic [7:0] l);
    @(negedge Clk);
    Start = 1'b1; StartAddr = a; Len = l;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Waits for a start bit, then follows the frame tick by tick. Every Clk
  // edge is assigned to a bit window by the ticks seen so far; Tx must stay
  // constant across each 16-tick window. Returns when the stop bit's 16th
  // tick has been seen.
  task automatic rx_frame(output logic [7:0] b, output int terr,
                          output int lat, output bit tmo);
    int         tcb;
    int         idx;
    int         n;
    logic       t;
    bit         found;
    logic [9:0] val;
    logic [9:0] seen;
    b = 8'h00; terr = 0; lat = 0; tmo = 1'b0; found = 1'b0;
    val = '1; seen = '0; t = 1'b0;
    while (!found && !tmo) begin
      @(posedge Clk);
      t = Tick;
      #1;
      lat++;
      if (Tx === 1'b0) found = 1'b1;
      else if (lat >= 200) tmo = 1'b1;
    end
    if (tmo) return;
    val[0] = Tx; seen[0] = 1'b1;
    tcb = t ? 1 : 0;
    n = 0;
    while (tcb < 160) begin
      @(posedge Clk);
      t = Tick;
      #1;
      n++;
      idx = tcb / 16;
      if (!seen[idx]) begin
        val[idx]  = Tx;
        seen[idx] = 1'b1;
      end else if (Tx !== val[idx]) begin
        terr++;
      end
      if (t) tcb++;
      if (n > 4000) begin
        tmo = 1'b1;
        return;
      end
    end
    if (val[0] !== 1'b0) terr++;
    if (val[9] !== 1'b1) terr++;
    b = val[8:1];
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++; if (Tx !== 1'b1)      begin errors++; $display("FAIL reset.tx got=%b want=1", Tx); end
    checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset.busy got=%b want=0", Busy); end
    checks++; if (Done !== 1'b0)    begin errors++; $display("FAIL reset.done got=%b want=0", Done); end
    checks++; if (MemRdEn !== 1'b0) begin errors++; $display("FAIL reset.rden got=%b want=0", MemRdEn); end
    checks++; if (MemAddr !== 8'h00) begin errors++; $display("FAIL reset.addr got=%h want=00", MemAddr); end
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] b; int te; int lat; bit to;
    mem[8'h10] = 8'hA5;
    addr_q.delete();
    start_dump(8'h10, 8'h01);
    checks++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h10) begin
      errors++; $display("FAIL single.fetch rden=%b addr=%h want rden=1 addr=10", MemRdEn, MemAddr); end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single.busy got=%b want=1", Busy); end
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hA5 || te != 0) begin
      errors++; $display("FAIL single.data byte=%h want=A5 timing_err=%0d timeout=%0b", b, te, to); end
    checks++; if (lat != 3) begin errors++; $display("FAIL single.latency got=%0d want=3 edges", lat); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL single.early_done got=%b want=0", Done); end
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hA5 || te != 0) begin
      errors++; $display("FAIL single.csum byte=%h want=A5 timing_err=%0d timeout=%0b", b, te, to); end
    checks++; if (Done !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL single.done done=%b busy=%b want done=1 busy=1", Done, Busy); end
    @(posedge Clk); #1;
    checks++; if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL single.after done=%b busy=%b want 0 0", Done, Busy); end
    checks++; if (addr_q.size() != 1) begin
      errors++; $display("FAIL single.fetches got=%0d want=1", addr_q.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] b; int te; int lat; bit to;
    logic [7:0] ex [4];
    ex[0] = 8'h01; ex[1] = 8'h02; ex[2] = 8'h04; ex[3] = 8'h07;
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h04;
    addr_q.delete();
    start_dump(8'hFE, 8'h03);
    for (int i = 0; i < 4; i++) begin
      rx_frame(b, te, lat, to);
      checks++; if (to || b !== ex[i] || te != 0) begin
        errors++; $display("FAIL wrap.frame%0d byte=%h want=%h timing_err=%0d timeout=%0b", i, b, ex[i], te, to); end
    end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL wrap.done got=%b want=1", Done); end
    checks++; if (addr_q.size() != 3 || addr_q[0] !== 8'hFE || addr_q[1] !== 8'hFF || addr_q[2] !== 8'h00) begin
      errors++; $display("FAIL wrap.addrs n=%0d first=%h,%h,%h want 3: fe,ff,00", addr_q.size(),
                         addr_q[0], addr_q[1], addr_q[2]); end
    @(posedge Clk); #1;
  endtask

  task automatic test_ignored();
    logic [7:0] b; int te; int lat; bit to; int viol;
    addr_q.delete();
    start_dump(8'h30, 8'h00);
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Tx !== 1'b1 || Busy !== 1'b0 || MemRdEn !== 1'b0) viol++;
    end
    checks++; if (viol != 0 || addr_q.size() != 0) begin
      errors++; $display("FAIL ignored.len0 bad_cycles=%0d fetches=%0d want 0 0", viol, addr_q.size()); end
    mem[8'h10] = 8'hA5; mem[8'h20] = 8'h3C;
    start_dump(8'h10, 8'h01);
    Start = 1'b1; StartAddr = 8'h20; Len = 8'h05;
    @(negedge Clk);
    Start = 1'b0;
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hA5 || te != 0) begin
      errors++; $display("FAIL ignored.data byte=%h want=A5 timing_err=%0d timeout=%0b", b, te, to); end
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hA5 || te != 0) begin
      errors++; $display("FAIL ignored.csum byte=%h want=A5 timing_err=%0d timeout=%0b", b, te, to); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL ignored.done got=%b want=1", Done); end
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Tx !== 1'b1 || MemRdEn !== 1'b0) viol++;
    end
    checks++; if (viol != 0 || addr_q.size() != 1) begin
      errors++; $display("FAIL ignored.extra bad_cycles=%0d fetches=%0d want 0 1", viol, addr_q.size()); end
  endtask

  task automatic test_irregular_tick();
    logic [7:0] b; int te; int lat; bit to;
    logic [7:0] ex [3];
    ex[0] = 8'h3C; ex[1] = 8'h81; ex[2] = 8'hBD;
    mem[8'h40] = 8'h3C; mem[8'h41] = 8'h81;
    tick_rand = 1'b1;
    start_dump(8'h40, 8'h02);
    for (int i = 0; i < 3; i++) begin
      rx_frame(b, te, lat, to);
      checks++; if (to || b !== ex[i] || te != 0) begin
        errors++; $display("FAIL irregular.frame%0d byte=%h want=%h timing_err=%0d timeout=%0b", i, b, ex[i], te, to); end
    end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL irregular.done got=%b want=1", Done); end
    tick_rand = 1'b0;
    repeat (25) @(posedge Clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b; int te; int lat; bit to; int n; int ndone;
    mem[8'h50] = 8'h11; mem[8'h51] = 8'h22; mem[8'h52] = 8'h33; mem[8'h60] = 8'h96;
    start_dump(8'h50, 8'h03);
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'h11 || te != 0) begin
      errors++; $display("FAIL rstmid.byte1 byte=%h want=11 timing_err=%0d timeout=%0b", b, te, to); end
    n = 0;
    while (Tx !== 1'b0 && n < 200) begin
      @(posedge Clk); #1; n++;
    end
    checks++; if (n >= 200) begin errors++; $display("FAIL rstmid.byte2_start got=timeout want=start bit"); end
    repeat (72) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk); #1;
    checks++; if (Tx !== 1'b1 || Busy !== 1'b0 || MemRdEn !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL rstmid.state tx=%b busy=%b rden=%b done=%b want 1 0 0 0", Tx, Busy, MemRdEn, Done); end
    @(negedge Clk);
    Rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done !== 1'b0 || Tx !== 1'b1) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL rstmid.quiet bad_cycles=%0d want=0", ndone); end
    start_dump(8'h60, 8'h01);
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'h96 || te != 0) begin
      errors++; $display("FAIL rstmid.redata byte=%h want=96 timing_err=%0d timeout=%0b", b, te, to); end
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'h96 || te != 0) begin
      errors++; $display("FAIL rstmid.recsum byte=%h want=96 timing_err=%0d timeout=%0b", b, te, to); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL rstmid.done got=%b want=1", Done); end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b; int te; int lat; bit to;
    mem[8'h70] = 8'h0F; mem[8'h71] = 8'hF0;
    start_dump(8'h70, 8'h01);
    rx_frame(b, te, lat, to);
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'h0F || te != 0 || Done !== 1'b1) begin
      errors++; $display("FAIL b2b.first csum=%h done=%b want csum=0F done=1 timeout=%0b", b, Done, to); end
    @(negedge Clk);
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b.idle busy=%b want=0", Busy); end
    Start = 1'b1; StartAddr = 8'h71; Len = 8'h01;
    @(negedge Clk);
    Start = 1'b0;
    checks++; if (MemRdEn !== 1'b1 || MemAddr !== 8'h71) begin
      errors++; $display("FAIL b2b.accept rden=%b addr=%h want rden=1 addr=71", MemRdEn, MemAddr); end
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hF0 || te != 0) begin
      errors++; $display("FAIL b2b.data byte=%h want=F0 timing_err=%0d timeout=%0b", b, te, to); end
    rx_frame(b, te, lat, to);
    checks++; if (to || b !== 8'hF0 || te != 0) begin
      errors++; $display("FAIL b2b.csum byte=%h want=F0 timing_err=%0d timeout=%0b", b, te, to); end
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL b2b.done got=%b want=1", Done); end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; StartAddr = 8'h00; Len = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_single_byte();
    test_wrap();
    test_ignored();
    test_irregular_tick();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
